// File: rtl/cic_comp_fir_if.sv
// Sample, coefficient and status bundle between the CIC decimator side and cic_comp_fir.
// The bypass control exists only when CIC_COMP_FIR_BYPASS_EN is defined.
interface cic_comp_fir_if;
  logic signed [7:0] d_in;
  logic              d_clk;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              overrun_clr;
  logic signed [7:0] d_out;
  logic              d_valid;
  logic              busy;
  logic              overrun;
`ifdef CIC_COMP_FIR_BYPASS_EN
  logic              bypass;

  modport master (
    output d_in, d_clk, coef_we, coef_addr, coef_data, overrun_clr, bypass,
    input  d_out, d_valid, busy, overrun
  );
  modport slave (
    input  d_in, d_clk, coef_we, coef_addr, coef_data, overrun_clr, bypass,
    output d_out, d_valid, busy, overrun
  );
`else
  modport master (
    output d_in, d_clk, coef_we, coef_addr, coef_data, overrun_clr,
    input  d_out, d_valid, busy, overrun
  );
  modport slave (
    input  d_in, d_clk, coef_we, coef_addr, coef_data, overrun_clr,
    output d_out, d_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/cic_comp_fir.sv
// Serial-MAC droop-compensation FIR behind the CIC decimator: one rounded, saturated
// output per CIC strobe edge. Optional bypass path under CIC_COMP_FIR_BYPASS_EN.
module cic_comp_fir #(
  parameter int NTAPS = 16,
  parameter int SHIFT = 7,
  parameter int ACC_W = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  cic_comp_fir_if.slave bus
);
  localparam int PTR_W = $clog2(NTAPS);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(32'sd1 <<< (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd128);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     dclk_q;
  logic signed [7:0]        line_q [NTAPS];
  logic signed [7:0]        line_d [NTAPS];
  logic signed [7:0]        coef_q [NTAPS];
  logic signed [7:0]        coef_d [NTAPS];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [7:0]        dout_q, dout_d;
  logic                     dvalid_q, dvalid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
`ifdef CIC_COMP_FIR_BYPASS_EN
  logic                     byp_q, byp_d;
  logic signed [7:0]        byp_data_q, byp_data_d;
`endif

  logic                     start_s;
  logic [PTR_W:0]           rd_sum_s;
  logic [PTR_W-1:0]         rd_idx_s;
  logic signed [15:0]       prod_s;

  function automatic logic signed [7:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> SHIFT;
    if (r > SAT_HI) begin
      return 8'sd127;
    end else if (r < SAT_LO) begin
      return 8'sh80;
    end else begin
      return r[7:0];
    end
  endfunction

  assign start_s = bus.d_clk & ~dclk_q;

  // Circular history read: x[n-tap] lives at (wr_ptr - tap) mod NTAPS.
  always_comb begin
    rd_sum_s = {1'b0, wr_ptr_q} + (PTR_W+1)'(NTAPS) - {1'b0, tap_q};
    if (rd_sum_s >= (PTR_W+1)'(NTAPS)) begin
      rd_idx_s = PTR_W'(rd_sum_s - (PTR_W+1)'(NTAPS));
    end else begin
      rd_idx_s = rd_sum_s[PTR_W-1:0];
    end
    prod_s = coef_q[tap_q] * line_q[rd_idx_s];
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    coef_d    = coef_q;
    wr_ptr_d  = wr_ptr_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;
`ifdef CIC_COMP_FIR_BYPASS_EN
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
`endif

    // A dropped sample outranks a simultaneous clear.
    if (start_s && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (bus.coef_we && (state_q == ST_IDLE) && !start_s &&
        ({1'b0, bus.coef_addr} < 5'(NTAPS))) begin
      coef_d[bus.coef_addr[PTR_W-1:0]] = bus.coef_data;
    end else begin
      coef_d = coef_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          line_d[wr_ptr_q] = bus.d_in;
          acc_d            = '0;
          tap_d            = '0;
`ifdef CIC_COMP_FIR_BYPASS_EN
          if (bus.bypass) begin
            byp_d      = 1'b1;
            byp_data_d = bus.d_in;
            state_d    = ST_ROUND;
          end else begin
            byp_d   = 1'b0;
            state_d = ST_MAC;
            busy_d  = 1'b1;
          end
`else
          state_d = ST_MAC;
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (tap_q == PTR_W'(NTAPS - 1)) begin
          state_d = ST_ROUND;
        end else begin
          tap_d = tap_q + PTR_W'(1);
        end
      end
      ST_ROUND: begin
`ifdef CIC_COMP_FIR_BYPASS_EN
        if (byp_q) begin
          dout_d = byp_data_q;
        end else begin
          dout_d = round_sat(acc_q);
        end
`else
        dout_d = round_sat(acc_q);
`endif
        dvalid_d = 1'b1;
        if (wr_ptr_q == PTR_W'(NTAPS - 1)) begin
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // d_clk_q resets high so a strobe already high at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dclk_q    <= 1'b1;
      wr_ptr_q  <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        line_q[i] <= '0;
        coef_q[i] <= (i == 0) ? 8'sd127 : 8'sd0;
      end
`ifdef CIC_COMP_FIR_BYPASS_EN
      byp_q      <= 1'b0;
      byp_data_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dclk_q    <= bus.d_clk;
      wr_ptr_q  <= wr_ptr_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      line_q    <= line_d;
      coef_q    <= coef_d;
`ifdef CIC_COMP_FIR_BYPASS_EN
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
`endif
    end
  end

  assign bus.d_out   = dout_q;
  assign bus.d_valid = dvalid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Serial multiply-accumulate FIR that sits directly downstream of the CIC decimator, in the same clk domain.
- Consumes the CIC's 8-bit signed sample and its level-type output strobe.
- Applies programmable droop-compensation taps and emits one rounded, saturated 8-bit sample per CIC output, with a single-cycle valid pulse.

Parameters:
- NTAPS, 16: number of taps; legal range 2..16.
- SHIFT, 7: output right-shift; coefficients are Q1.7.
- ACC_W, 20: accumulator width; must be at least 16 + ceil(log2(NTAPS)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- d_in  in  8  signed sample from the CIC
- d_clk  in  1  CIC output strobe (level signal, high roughly half a period); a rising edge marks a new d_in
- coef_we  in  1  coefficient write enable
- coef_addr  in  4  tap index (0 = newest sample)
- coef_data  in  8  signed coefficient, Q1.7
- overrun_clr  in  1  clears overrun
- d_out  out  8  signed filtered sample
- d_valid  out  1  one-cycle pulse, d_out new
- busy  out  1  high while a computation is in progress
- overrun  out  1  sticky dropped-sample flag

Behaviour:
- Reset (async, rst_n=0):
  - d_out=0, d_valid=0, busy=0, overrun=0.
  - Delay line all zero; wr_ptr=0; accumulator=0; state IDLE.
  - coef[0]=127, all other coefs 0 (near-passthrough).
  - d_clk_q resets to 1, so a d_clk already high at reset release is not treated as an edge.
- Edge detect: start = d_clk & ~d_clk_q, with d_clk_q registered every cycle. Only rising edges matter; level duration is irrelevant.
- States:
  - IDLE: on start, write d_in to line[wr_ptr], clear acc, tap=0, go to MAC, busy=1.
  - MAC: NTAPS cycles. acc += coef[tap] * x[n-tap], where x[n-tap] = line[(wr_ptr - tap) mod NTAPS]. 8x8 signed product (16 bits), sign-extended to ACC_W. After the last tap, go to ROUND.
  - ROUND: r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic. Saturate to [-128, 127]. Register d_out, pulse d_valid, advance wr_ptr (wrapping at NTAPS-1 to 0), go to IDLE, busy=0.
- Latency: start seen at cycle N -> d_valid high at cycle N+NTAPS+2. d_out holds its value until the next d_valid.
- Throughput: the CIC decimation ratio must be at least NTAPS+3 clk cycles per sample.
- Overrun: a start while state != IDLE drops that sample (no line write, no output) and sets overrun.
  - overrun clears only on reset or overrun_clr.
  - start and overrun_clr in the same cycle: set wins.
- Coefficient writes:
  - Accepted only when state is IDLE and no start occurs in that cycle; otherwise silently ignored.
  - coef_addr >= NTAPS is ignored.
- Reset mid-operation: everything returns to reset values immediately. No d_valid is produced for the interrupted sample.

Optional Feature:
- Macro: CIC_COMP_FIR_BYPASS_EN.
- Defined: adds input port bypass (1 bit).
  - When bypass=1 and start occurs, d_out=d_in and d_valid pulses at N+2. No MAC runs; busy stays 0.
  - The sample is still written to the delay line and wr_ptr advances, so history stays coherent on un-bypass.
  - bypass is sampled only at start.
- Undefined: no bypass port; behaviour exactly as above.

Test Plan:
- Impulse: after reset (default coefs), edges every 32 cycles; d_in=64 on the first edge, 0 afterwards -> d_out sequence 64, 0, 0, ... Each d_valid lands exactly 18 cycles after its start detection (NTAPS=16).
- Moving average: write coef[0..3]=32, others 0; step d_in=100 on consecutive edges -> d_out 25, 50, 75, 100, 100, ...
- Saturation: all 16 coefs=127.
  - d_in=127 steady -> d_out settles at 127.
  - Then d_in=-128 steady -> d_out settles at -128; no wrap.
- Overrun: two d_clk rising edges 5 cycles apart -> exactly one d_valid; overrun=1 stays set; pulsing overrun_clr -> overrun=0.
- Coef write while busy: write coef[0]=0 during MAC -> ignored; an impulse of 64 still yields 64.
- Async reset mid-MAC: drop rst_n 6 cycles after start -> d_out=0 and busy=0 immediately, no d_valid; coef[0] back to 127. A d_clk held high across release produces no output until the next rising edge.
